// File: rtl/quad_encoder_monitor.sv
// quad_encoder_monitor: multi-channel quadrature decoder with position, per-revolution
// edge count, index (Z) counting, error tracking and a registered read port.
module quad_encoder_monitor #(
    parameter int NCH   = 3,
    parameter int CNT_W = 32,
    parameter int PPR_W = 16,
    parameter bit ZRST  = 1'b0
) (
    input  logic             Clk,
    input  logic             rset,
    input  logic [NCH-1:0]   AIn,
    input  logic [NCH-1:0]   BIn,
    input  logic [NCH-1:0]   ZIn,
    input  logic             rd_en,
    input  logic [2:0]       rd_ch,
    input  logic [1:0]       rd_sel,
    input  logic [NCH-1:0]   flag_clr,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    output logic [NCH-1:0]   zflagged,
    output logic [NCH-1:0]   dir,
    output logic             err_any
);
    localparam logic [PPR_W-1:0] PPR_MAX = '1;
    logic [CNT_W-1:0] pos [NCH];
    logic [CNT_W-1:0] zcnt [NCH];
    logic [PPR_W-1:0] rev [NCH];
    logic [PPR_W-1:0] ppr [NCH];
    logic [PPR_W-1:0] rev_inc [NCH];
    logic [7:0]       err [NCH];
    logic [1:0]       dlt [NCH];
    logic [NCH-1:0]   armed, pa, pb, pz, fwd, bwd, bad, zr, err_nz;
    logic [31:0]      rd_mux;
    // {A, A^B} turns the Gray sequence into a binary phase, so the phase delta
    // directly gives +1 (1), -1 (3) or an illegal double change (2).
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            dlt[i] = {AIn[i], AIn[i] ^ BIn[i]} - {pa[i], pa[i] ^ pb[i]};
            fwd[i] = dlt[i] == 2'd1;
            bwd[i] = dlt[i] == 2'd3;
            bad[i] = dlt[i] == 2'd2;
            zr[i] = ZIn[i] & ~pz[i];
            rev_inc[i] = ((fwd[i] | bwd[i]) && rev[i] != PPR_MAX) ? rev[i] + PPR_W'(1) : rev[i];
            err_nz[i] = err[i] != 8'd0;
        end
    end
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NCH; i++)
            if (rd_ch == 3'(i))
                rd_mux = rd_sel == 2'd0 ? 32'(pos[i]) :
                         rd_sel == 2'd1 ? 32'(ppr[i]) :
                         rd_sel == 2'd2 ? 32'(zcnt[i]) :
                         {16'd0, err[i], 5'd0, armed[i], dir[i], zflagged[i]};
    end
    assign err_any = |err_nz;
    always_ff @(posedge Clk) begin
        pa <= AIn;
        pb <= BIn;
        pz <= ZIn;
        if (rset) begin
            armed    <= '0;
            zflagged <= '0;
            dir      <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            for (int i = 0; i < NCH; i++) begin
                pos[i]  <= '0;
                zcnt[i] <= '0;
                rev[i]  <= '0;
                ppr[i]  <= '0;
                err[i]  <= '0;
            end
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= rd_mux;
            for (int i = 0; i < NCH; i++) begin
                if (ZRST && zr[i])
                    pos[i] <= '0;
                else if (fwd[i])
                    pos[i] <= pos[i] + CNT_W'(1);
                else if (bwd[i])
                    pos[i] <= pos[i] - CNT_W'(1);
                if (fwd[i] | bwd[i])
                    dir[i] <= fwd[i];
                err[i] <= bad[i] ? (err[i] == 8'hff ? err[i] : err[i] + 8'd1) :
                          flag_clr[i] ? 8'd0 : err[i];
                // Z rise takes priority over flag_clr for armed/zflagged.
                if (zr[i]) begin
                    if (armed[i])
                        ppr[i] <= rev_inc[i];
                    rev[i]      <= '0;
                    zcnt[i]     <= zcnt[i] + CNT_W'(1);
                    armed[i]    <= 1'b1;
                    zflagged[i] <= 1'b1;
                end else begin
                    rev[i] <= rev_inc[i];
                    if (flag_clr[i]) begin
                        armed[i]    <= 1'b0;
                        zflagged[i] <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_quad_encoder_monitor.sv
// tb_quad_encoder_monitor: directed and random stimulus against a step-level model,
// run on a ZRST=0 and a ZRST=1 instance driven by the same inputs.
module tb_quad_encoder_monitor;
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;
    logic        rset, rd_en;
    logic [2:0]  AIn, BIn, ZIn, flag_clr, rd_ch;
    logic [1:0]  rd_sel;
    logic [31:0] rd_data, rd_data_z;
    logic        rd_valid, rd_valid_z, err_any, err_any_z;
    logic [2:0]  zflagged, zflagged_z, dir, dir_z;

    quad_encoder_monitor dut (
        .Clk(Clk), .rset(rset), .AIn(AIn), .BIn(BIn), .ZIn(ZIn), .rd_en(rd_en),
        .rd_ch(rd_ch), .rd_sel(rd_sel), .flag_clr(flag_clr), .rd_data(rd_data),
        .rd_valid(rd_valid), .zflagged(zflagged), .dir(dir), .err_any(err_any)
    );
    quad_encoder_monitor #(.ZRST(1'b1)) dutz (
        .Clk(Clk), .rset(rset), .AIn(AIn), .BIn(BIn), .ZIn(ZIn), .rd_en(rd_en),
        .rd_ch(rd_ch), .rd_sel(rd_sel), .flag_clr(flag_clr), .rd_data(rd_data_z),
        .rd_valid(rd_valid_z), .zflagged(zflagged_z), .dir(dir_z), .err_any(err_any_z)
    );

    int total = 0, bad = 0;
    // Model: phase per channel (0..3 along 00,01,11,10) and the observable state.
    int ph [3];
    logic [31:0] mpos [2][3];
    logic [31:0] mzc [3];
    int mrev [3], mppr [3], merr [3];
    bit marm [3], mzf [3], mdir [3], zl [3];
    logic [31:0] last_rd, last_rdz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mexp(input int ch, input int sel, input int z);
        if (ch >= 3) return 32'd0;
        case (sel)
            0: return mpos[z][ch];
            1: return 32'(mppr[ch]);
            2: return mzc[ch];
            default: return {16'd0, 8'(merr[ch]), 5'd0, marm[ch], mdir[ch], mzf[ch]};
        endcase
    endfunction

    task automatic drive_in();
        for (int c = 0; c < 3; c++) begin
            AIn[c] = ph[c][1];
            BIn[c] = ph[c][1] ^ ph[c][0];
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            mpos[0][c] = 0; mpos[1][c] = 0; mzc[c] = 0;
            mrev[c] = 0; mppr[c] = 0; merr[c] = 0;
            marm[c] = 0; mzf[c] = 0; mdir[c] = 0;
        end
        last_rd = 0;
        last_rdz = 0;
    endtask

    task automatic chk_flags();
        logic [2:0] ez, ed;
        logic ee;
        ee = 1'b0;
        for (int c = 0; c < 3; c++) begin
            ez[c] = mzf[c];
            ed[c] = mdir[c];
            if (merr[c] != 0) ee = 1'b1;
        end
        chk("zflagged", zflagged, ez);
        chk("zflagged_z", zflagged_z, ez);
        chk("dir", dir, ed);
        chk("dir_z", dir_z, ed);
        chk("err_any", err_any, ee);
        chk("err_any_z", err_any_z, ee);
    endtask

    // One cycle: a = step per channel (+1, -1, 0, 2 = illegal double change).
    task automatic tick(input int a0, input int a1, input int a2, input logic [2:0] z, input logic [2:0] clr);
        int a [3];
        a[0] = a0; a[1] = a1; a[2] = a2;
        @(negedge Clk);
        rd_en = 1'b0;
        flag_clr = clr;
        ZIn = z;
        for (int c = 0; c < 3; c++) ph[c] += a[c];
        drive_in();
        for (int c = 0; c < 3; c++) begin
            bit zr, st;
            int ri;
            zr = z[c] && !zl[c];
            zl[c] = z[c];
            st = (a[c] == 1 || a[c] == -1);
            ri = (st && mrev[c] < 65535) ? mrev[c] + 1 : mrev[c];
            if (st) begin
                mdir[c] = (a[c] == 1);
                for (int k = 0; k < 2; k++) mpos[k][c] += 32'(a[c]);
            end
            if (a[c] == 2) merr[c] = merr[c] < 255 ? merr[c] + 1 : 255;
            else if (clr[c]) merr[c] = 0;
            if (zr) begin
                if (marm[c]) mppr[c] = ri;
                mrev[c] = 0;
                mzc[c] = mzc[c] + 1;
                marm[c] = 1;
                mzf[c] = 1;
                mpos[1][c] = 0;
            end else begin
                mrev[c] = ri;
                if (clr[c]) begin
                    marm[c] = 0;
                    mzf[c] = 0;
                end
            end
        end
        @(posedge Clk); #1;
        chk_flags();
        chk("rdv_idle", rd_valid, 0);
        chk("rdv_idle_z", rd_valid_z, 0);
        chk("rd_hold", rd_data, last_rd);
        chk("rd_hold_z", rd_data_z, last_rdz);
    endtask

    task automatic rd(input int ch, input int sel, input string tag);
        @(negedge Clk);
        rd_en = 1'b1;
        rd_ch = 3'(ch);
        rd_sel = 2'(sel);
        flag_clr = 3'b000;
        @(posedge Clk); #1;
        last_rd = mexp(ch, sel, 0);
        last_rdz = mexp(ch, sel, 1);
        chk({tag, "_v"}, rd_valid, 1);
        chk(tag, rd_data, last_rd);
        chk({tag, "_vz"}, rd_valid_z, 1);
        chk({tag, "_z"}, rd_data_z, last_rdz);
    endtask

    task automatic do_reset(input bit with_rd);
        @(negedge Clk);
        rset = 1'b1;
        rd_en = with_rd;
        flag_clr = 3'b000;
        @(posedge Clk); #1;
        chk("rst_rdv", rd_valid, 0);
        chk("rst_rdv_z", rd_valid_z, 0);
        chk("rst_rdd", rd_data, 0);
        chk("rst_zf", zflagged, 0);
        chk("rst_err", err_any, 0);
        @(negedge Clk);
        rd_en = 1'b0;
        rset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [2:0] zr_rand, clr_rand;
        rset = 1'b1; rd_en = 1'b0; rd_ch = 3'd0; rd_sel = 2'd0; flag_clr = 3'b000;
        for (int c = 0; c < 3; c++) begin
            ph[c] = 2;
            zl[c] = 1;
        end
        ZIn = 3'b111;
        drive_in();
        model_reset();
        do_reset(1'b0);
        // A=B=Z=1 held through release: no step, no Z edge, no error
        tick(0, 0, 0, 3'b111, 3'b000);
        rd(0, 0, "pos0_rst");
        rd(0, 2, "zc0_rst");
        rd(0, 3, "st0_rst");
        // ch1 reverse 5 steps
        repeat (5) tick(0, -1, 0, 3'b111, 3'b000);
        rd(1, 0, "pos1_rev");
        chk("pos1_lit", rd_data, 32'hFFFF_FFFB);
        chk("dir1_lit", {31'd0, dir[1]}, 0);
        // ch0 forward 4000 steps, Z at step 0 and at step 4000
        tick(0, 0, 0, 3'b000, 3'b000);
        tick(0, 0, 0, 3'b001, 3'b000);
        repeat (3999) tick(1, 0, 0, 3'b000, 3'b000);
        tick(1, 0, 0, 3'b001, 3'b000);
        rd(0, 1, "ppr0");
        chk("ppr0_lit", rd_data, 32'd4000);
        rd(0, 2, "zc0");
        chk("zc0_lit", rd_data, 32'd2);
        rd(0, 0, "pos0");
        chk("pos0_lit", rd_data, 32'd4000);
        chk("dir0_lit", {31'd0, dir[0]}, 1);
        // ch2 00 -> 11 illegal, then clear
        tick(0, 0, -1, 3'b000, 3'b000);
        tick(0, 0, -1, 3'b000, 3'b000);
        tick(0, 0, 2, 3'b000, 3'b000);
        rd(2, 3, "st2_err");
        chk("err2_lit", {24'd0, rd_data[15:8]}, 1);
        chk("err_any_lit", {31'd0, err_any}, 1);
        rd(2, 0, "pos2_ill");
        tick(0, 0, 0, 3'b000, 3'b100);
        chk("err_any_clr", {31'd0, err_any}, 0);
        // out-of-range channel, then four back-to-back field reads
        rd(7, 0, "ch7");
        chk("ch7_lit", rd_data, 0);
        rd(0, 0, "b2b0");
        rd(0, 1, "b2b1");
        rd(0, 2, "b2b2");
        rd(0, 3, "b2b3");
        tick(0, 0, 0, 3'b000, 3'b000);
        // ZRST instance: step and Z rise in the same cycle on ch1
        tick(0, 0, 0, 3'b010, 3'b000);
        repeat (3) tick(0, 1, 0, 3'b000, 3'b000);
        tick(0, 1, 0, 3'b010, 3'b000);
        rd(1, 0, "zrst_pos");
        chk("zrst_pos_lit", rd_data_z, 0);
        rd(1, 1, "zrst_ppr");
        chk("zrst_ppr_lit", rd_data_z, 32'd4);
        // error count saturation
        repeat (260) tick(0, 0, 2, 3'b000, 3'b000);
        rd(2, 3, "st2_sat");
        chk("err2_sat_lit", {24'd0, rd_data[15:8]}, 255);
        // random traffic
        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < 300; n++) begin
                for (int c = 0; c < 3; c++) zr_rand[c] = ($urandom_range(0, 5) == 0);
                clr_rand = ($urandom_range(0, 30) == 0) ? 3'($urandom) : 3'b000;
                tick(($urandom_range(0, 9) < 4) ? 1 : ($urandom_range(0, 5) < 4) ? -1 :
                         ($urandom_range(0, 3) == 0) ? 2 : 0,
                     ($urandom_range(0, 9) < 4) ? 1 : ($urandom_range(0, 5) < 4) ? -1 :
                         ($urandom_range(0, 3) == 0) ? 2 : 0,
                     ($urandom_range(0, 9) < 4) ? 1 : ($urandom_range(0, 5) < 4) ? -1 :
                         ($urandom_range(0, 3) == 0) ? 2 : 0,
                     zr_rand, clr_rand);
            end
            for (int ch = 0; ch < 4; ch++)
                for (int s = 0; s < 4; s++) rd(ch, s, "rand_rd");
        end
        // reset asserted with a read pending suppresses rd_valid
        do_reset(1'b1);
        tick(0, 0, 0, ZIn, 3'b000);
        rd(0, 0, "pos0_rst2");
        rd(0, 2, "zc0_rst2");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/quad_encoder_monitor.md
QUAD_ENCODER_MONITOR -- requirements
Module: quad_encoder_monitor

Interface
REQ-001 Parameter NCH, default 3: number of encoder channels, range 1..8.
REQ-002 Parameter CNT_W, default 32: position and Z-count width, range 16..32.
REQ-003 Parameter PPR_W, default 16: per-revolution edge-count width.
REQ-004 Parameter ZRST, default 0: when 1, position is zeroed on each Z rising edge.
REQ-005 Clk  in  1  system clock; single clock domain; all logic on rising edge.
REQ-006 rset  in  1  reset, synchronous, active-high.
REQ-007 AIn  in  NCH  channel A per encoder, already synchronised/filtered by caller.
REQ-008 BIn  in  NCH  channel B per encoder, already synchronised/filtered.
REQ-009 ZIn  in  NCH  index per encoder, already synchronised/filtered.
REQ-010 rd_en  in  1  one-cycle read request.
REQ-011 rd_ch  in  3  channel to read.
REQ-012 rd_sel  in  2  field: 0 position, 1 PPR, 2 Z count, 3 status.
REQ-013 flag_clr  in  NCH  per-channel clear of sticky Z flag and error count.
REQ-014 rd_data  out  32  read result, zero-extended.
REQ-015 rd_valid  out  1  one-cycle strobe qualifying rd_data.
REQ-016 zflagged  out  NCH  sticky "index seen" per channel.
REQ-017 dir  out  NCH  last valid direction per channel, 1 = forward.
REQ-018 err_any  out  1  OR of all channels' error count nonzero.

Function
REQ-019 Each channel shall register previous {A,B} every cycle; decode compares previous vs current.
REQ-020 Transitions 00->01->11->10->00 shall be forward (+1); reverse order shall be -1; no change shall be 0.
REQ-021 Both bits changing in one cycle shall be illegal: position unchanged, 8-bit error count incremented, saturating at 255.
REQ-022 Position shall be CNT_W bits, two's-complement, wrapping modulo 2^CNT_W in both directions.
REQ-023 dir shall update only on a valid +1/-1 step; held otherwise.
REQ-024 Per-rev counter (PPR_W bits) shall count valid steps of either sign since last Z rise, saturating at all-ones.
REQ-025 Z rising edge = current Z high, previous Z low; detected per channel on registered previous Z.
REQ-026 On Z rise with channel armed: PPR register <= per-rev counter including any step in that same cycle; per-rev counter <= 0; Z count += 1 (wrapping).
REQ-027 First Z rise after reset or flag_clr shall only arm the channel, clear per-rev counter, increment Z count and set zflagged; PPR register unchanged.
REQ-028 zflagged shall set on any Z rise and hold until reset or flag_clr of that channel.
REQ-029 ZRST=1: on Z rise position shall become 0, discarding a same-cycle step; ZRST=0: position unaffected by Z.
REQ-030 flag_clr[i] shall clear zflagged[i], error count[i] and armed[i]; position, Z count, PPR register retained; a same-cycle Z rise or illegal step shall win over the clear.
REQ-031 Read: rd_en at cycle N shall give rd_data and rd_valid=1 at cycle N+1, sampling state as registered at end of cycle N.
REQ-032 Status word: bit0 zflagged, bit1 dir, bit2 armed, bits15:8 error count, others 0.
REQ-033 rd_ch >= NCH shall return rd_data = 0 with rd_valid = 1.
REQ-034 rd_valid shall be low in every cycle not following an rd_en; rd_data shall hold its last value when rd_valid is low.
REQ-035 Back-to-back rd_en every cycle shall be supported at full rate.

Reset
REQ-036 While rset high: positions, per-rev counters, PPR registers, Z counts, error counts, armed, zflagged, dir, rd_data, rd_valid shall all be 0.
REQ-037 Previous A/B/Z registers shall load current inputs during reset so no step or Z edge is decoded on the first cycle after release.
REQ-038 rset asserted mid-read shall suppress the pending rd_valid.

Verification
REQ-039 Reset release with A=1,B=1,Z=1 held -> position 0, Z count 0, no error, rd_valid 0.
REQ-040 Ch0 forward 4000 steps, Z pulse at step 0 and 4000 -> PPR read 4000, Z count 2, dir 1, position 4000 (ZRST=0).
REQ-041 Ch1 reverse 5 steps from reset -> position read 0xFFFF_FFFB, dir 0.
REQ-042 Ch2 AB 00->11 -> position unchanged, status bits15:8 = 1, err_any 1; then flag_clr[2] -> err_any 0.
REQ-043 ZRST=1, step and Z rise in same cycle -> position 0, PPR includes that step.
REQ-044 rd_en with rd_ch=7, NCH=3 -> next cycle rd_valid 1, rd_data 0; consecutive rd_en on 4 fields -> 4 consecutive valid strobes.
